// File: rtl/grid_row_packer.sv
// Packs an ASCII puzzle byte stream into 2-bit-per-cell row words over valid/ready.
// Optional: define ROW_PACKER_PAD_EN to pad short rows, drop overlong cells and expose pad_evt.
module grid_row_packer #(
  parameter int WIDTH    = 141,
  parameter int HEIGHT   = 142,
  parameter int ROW_BITS = 2*WIDTH,
  parameter int IDX_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_BITS-1:0] out_row,
  output logic [IDX_W-1:0]    out_row_idx,
  output logic                out_last,
  output logic                done,
  output logic                err
`ifdef ROW_PACKER_PAD_EN
  ,
  output logic                pad_evt
`endif
);

`ifdef ROW_PACKER_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FILL, EMIT, DONE, ERR} state_t;

  state_t              state;
  logic [CW-1:0]       col, col_nxt;
  logic [IDX_W-1:0]    row;
  logic [ROW_BITS-1:0] shadow, shadow_nxt;
  logic [1:0]          code;
  logic                is_cell, is_nl, bad;
  logic                full, drop, row_end, final_row, blank, row_full;
  logic                accept, to_err, to_emit, to_store;
`ifdef ROW_PACKER_PAD_EN
  logic                trunc;
`endif

  always_comb begin
    code    = '0;
    is_cell = 1'b0;
    is_nl   = 1'b0;
    bad     = 1'b0;
    case (in_data)
      8'h2E:   is_cell = 1'b1;
      8'h5E:   begin code = 2'd1; is_cell = 1'b1; end
      8'h53:   begin code = 2'd2; is_cell = 1'b1; end
      8'h0A:   is_nl = 1'b1;
      8'h0D:   ;
      default: bad = 1'b1;
    endcase
  end

  assign full      = (col == CW'(WIDTH));
  assign drop      = is_cell & full;
  assign row_end   = is_nl | in_last;
  assign final_row = (row == IDX_W'(HEIGHT - 1));

  // The terminating byte may itself be a cell, so row-end decisions use the post-store view.
  always_comb begin
    shadow_nxt = shadow;
    col_nxt    = col;
    if (is_cell && !full) begin
      for (int unsigned i = 0; i < WIDTH; i++)
        if (col == CW'(i)) shadow_nxt[2*i +: 2] = code;
      col_nxt = CW'(col + 1'b1);
    end
  end

  assign blank    = (col_nxt == '0);
  assign row_full = (col_nxt == CW'(WIDTH));
  assign accept   = in_valid & in_ready & (state == FILL);

  always_comb begin
    to_err   = 1'b0;
    to_emit  = 1'b0;
    to_store = 1'b0;
    if (accept) begin
      if (bad || (drop && !PAD_EN))                         to_err   = 1'b1;
      else if (!row_end)                                    to_store = 1'b1;
      else if (blank)                                       to_err   = in_last;
      else if ((in_last && !final_row) || (!row_full && !PAD_EN)) to_err = 1'b1;
      else                                                  to_emit  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      out_last    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      shadow      <= '0;
      col         <= '0;
      row         <= '0;
`ifdef ROW_PACKER_PAD_EN
      trunc       <= 1'b0;
      pad_evt     <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (to_err) begin
            state    <= ERR;
            err      <= 1'b1;
            in_ready <= 1'b0;
          end else if (to_store) begin
            shadow <= shadow_nxt;
            col    <= col_nxt;
`ifdef ROW_PACKER_PAD_EN
            trunc  <= trunc | drop;
`endif
          end else if (to_emit) begin
            out_row     <= shadow_nxt;
            out_row_idx <= row;
            out_last    <= final_row;
            out_valid   <= 1'b1;
            in_ready    <= 1'b0;
            shadow      <= '0;
            col         <= '0;
            state       <= EMIT;
`ifdef ROW_PACKER_PAD_EN
            pad_evt     <= trunc | drop | !row_full;
            trunc       <= 1'b0;
`endif
          end
        end
        EMIT: begin
`ifdef ROW_PACKER_PAD_EN
          pad_evt <= 1'b0;
`endif
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
              row      <= row + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_row_packer.sv
// Directed bench for grid_row_packer at WIDTH=4, HEIGHT=2 with hand-computed row words.
module tb_grid_row_packer;
  localparam int W = 4;
  localparam int H = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [7:0]     in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] out_row;
  logic [15:0]    out_row_idx;
  logic           out_last;
  logic           done;
  logic           err;
`ifdef ROW_PACKER_PAD_EN
  logic           pad_evt;
`endif

  int tests = 0;
  int failed = 0;
  logic [31:0] rows_q[$];
  logic [31:0] idx_q[$];
  logic [31:0] last_q[$];
  logic [31:0] pad_q[$];

  always #5 clk = ~clk;

  grid_row_packer #(.WIDTH(W), .HEIGHT(H), .ROW_BITS(2*W), .IDX_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .done(done), .err(err)
`ifdef ROW_PACKER_PAD_EN
    , .pad_evt(pad_evt)
`endif
  );

  // Record each handshake midway through the cycle that completes it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rows_q.push_back(32'(out_row));
      idx_q.push_back(32'(out_row_idx));
      last_q.push_back(32'(out_last));
`ifdef ROW_PACKER_PAD_EN
      pad_q.push_back(32'(pad_evt));
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    rows_q.delete(); idx_q.delete(); last_q.delete(); pad_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_at_end);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], last_at_end && (i == s.len() - 1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_rows(input string tag, input logic [7:0] r0, input logic [7:0] r1);
    check({tag, "_nrows"}, 32'(rows_q.size()), 32'd2);
    if (rows_q.size() >= 2) begin
      check({tag, "_row0"}, rows_q[0], 32'(r0));
      check({tag, "_idx0"}, idx_q[0], 32'd0);
      check({tag, "_last0"}, last_q[0], 32'd0);
      check({tag, "_row1"}, rows_q[1], 32'(r1));
      check({tag, "_idx1"}, idx_q[1], 32'd1);
      check({tag, "_last1"}, last_q[1], 32'd1);
    end
  endtask

  initial begin
    // 1: basic two-row stream plus reset state
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("rst_in_ready_after", 32'(in_ready), 32'd1);
    send_str("..S.\n", 1'b0);
    check("t1_latency", 32'(out_valid), 32'd1);
    send_str("^.^.\n", 1'b0);
    wait_done("t1");
    check_rows("t1", 8'h20, 8'h11);
    check("t1_in_ready_done", 32'(in_ready), 32'd0);
    check("t1_out_valid_done", 32'(out_valid), 32'd0);

    // 2: backpressure on row 0
    do_reset();
    out_ready = 1'b0;
    send_str("..S.\n", 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_row", 32'(out_row), 32'h20);
      check("t2_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_str("^.^.\n", 1'b0);
    wait_done("t2");
    check_rows("t2", 8'h20, 8'h11);

    // 3: CR ignored, final row ended by in_last without newline
    do_reset();
    send_str("..S.\r\n^^^^", 1'b1);
    wait_done("t3");
    check_rows("t3", 8'h20, 8'h55);

    // 4: illegal byte, then short row
    do_reset();
    send_str("..x", 1'b0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("t4_in_ready_held", 32'(in_ready), 32'd0);
    check("t4_nrows", 32'(rows_q.size()), 32'd0);
    do_reset();
    send_str("..\n", 1'b0);
    @(posedge clk); #1;
`ifdef ROW_PACKER_PAD_EN
    check("t4_short_nrows", 32'(rows_q.size()), 32'd1);
    if (rows_q.size() >= 1) begin
      check("t4_short_row", rows_q[0], 32'h00);
      check("t4_short_pad", pad_q[0], 32'd1);
    end
    check("t4_short_err", 32'(err), 32'd0);
`else
    check("t4_short_err", 32'(err), 32'd1);
    check("t4_short_nrows", 32'(rows_q.size()), 32'd0);
`endif

    // 5: reset mid-row
    do_reset();
    send_str("^^", 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_row", 32'(out_row), 32'd0);
    check("t5_idx", 32'(out_row_idx), 32'd0);
    check("t5_last", 32'(out_last), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_err", 32'(err), 32'd0);
    do_reset();
    send_str("..S.\n^.^.\n", 1'b0);
    wait_done("t5");
    check_rows("t5", 8'h20, 8'h11);

    // 6: leading blank line
    do_reset();
    send_str("\n..S.\n^.^.\n", 1'b0);
    wait_done("t6");
    check_rows("t6", 8'h20, 8'h11);

    // 7: overlong row
    do_reset();
    send_str("....^", 1'b0);
`ifdef ROW_PACKER_PAD_EN
    send_byte(8'h0A, 1'b0);
    @(posedge clk); #1;
    check("t7_nrows", 32'(rows_q.size()), 32'd1);
    if (rows_q.size() >= 1) begin
      check("t7_row", rows_q[0], 32'h00);
      check("t7_pad", pad_q[0], 32'd1);
    end
`else
    check("t7_err", 32'(err), 32'd1);
    check("t7_nrows", 32'(rows_q.size()), 32'd0);
`endif

    // 8: in_last arrives before the final row
    do_reset();
    send_str("..S.\n", 1'b1);
    @(posedge clk); #1;
    check("t8_err", 32'(err), 32'd1);
    check("t8_nrows", 32'(rows_q.size()), 32'd0);
    check("t8_done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
